serial_divider: RTL

//  Bit-serial restoring divider, the inverse of serialMultiplier. Same

---
 rtl/serial_divider.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
//   Bit-serial restoring divider. An accepted Enable latches the operands, one
//   quotient bit is resolved per clock (MSB first), and after WIDTH iterations
//   quotient/remainder are loaded and done is raised. The results and done hold
//   until the next accepted Enable or reset.
//
// Optional feature macro: SERIAL_DIV_DBZ_EN
//   When defined, adds the div_by_zero output: the captured (divisor == 0)
//   flag, visible only while done is high.
//
// Ports
//   clk          in   1      clock, all state changes on rising edge
//   reset        in   1      synchronous, active-high reset
//   Enable       in   1      start request, accepted only in IDLE or DONE
//   dividend     in   WIDTH  unsigned numerator, sampled on accepted Enable
//   divisor      in   WIDTH  unsigned denominator, sampled on accepted Enable
//   quotient     out  WIDTH  registered floor(dividend / divisor)
//   remainder    out  WIDTH  registered dividend - quotient * divisor
//   done         out  1      results valid for the last operation
//   div_by_zero  out  1      (SERIAL_DIV_DBZ_EN only) last divisor was zero
// -----------------------------------------------------------------------------
module serial_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
`ifdef SERIAL_DIV_DBZ_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] d_r;      // latched divisor
  logic [WIDTH-1:0] q_r;      // working quotient, dividend bits shift out of its top
  // The partial remainder is always < divisor between iterations, so its
  // extra top bit is always 0 once stored; the extra bit only matters in the
  // shifted value and the trial subtraction below.
  logic [WIDTH-1:0] r_r;
`ifdef SERIAL_DIV_DBZ_EN
  logic             dbz_cap_r;
`endif

  logic [WIDTH:0]   shift_r_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] next_r_s;
  logic [WIDTH-1:0] next_q_s;
  logic             accept_s;
  logic             last_s;

  // One restoring-division iteration on the current working registers.
  always_comb begin
    shift_r_s = {r_r, q_r[WIDTH-1]};
    trial_s   = shift_r_s - {1'b0, d_r};
    // Sign bit of the WIDTH+1 bit trial tells whether the subtract went negative.
    if (trial_s[WIDTH] == 1'b0) begin
      next_r_s = trial_s[WIDTH-1:0];
      next_q_s = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      next_r_s = shift_r_s[WIDTH-1:0];
      next_q_s = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Start acceptance (IDLE/DONE only) and final-iteration detect.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = Enable;
      DONE:    accept_s = Enable;
      RUN:     accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
    if (count_r == CW'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Controller and datapath registers, including the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= '0;
      d_r       <= '0;
      q_r       <= '0;
      r_r       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
`ifdef SERIAL_DIV_DBZ_EN
      dbz_cap_r   <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else if (accept_s) begin
      state_r <= RUN;
      count_r <= '0;
      d_r     <= divisor;
      q_r     <= dividend;
      r_r     <= '0;
      done    <= 1'b0;
`ifdef SERIAL_DIV_DBZ_EN
      dbz_cap_r   <= (divisor == {WIDTH{1'b0}});
      div_by_zero <= 1'b0;
`endif
    end else if (state_r == RUN) begin
      q_r     <= next_q_s;
      r_r     <= next_r_s;
      count_r <= count_r + CW'(1);
      if (last_s) begin
        state_r   <= DONE;
        quotient  <= next_q_s;
        remainder <= next_r_s;
        done      <= 1'b1;
`ifdef SERIAL_DIV_DBZ_EN
        div_by_zero <= dbz_cap_r;
`endif
      end else begin
        state_r <= RUN;
      end
    end else if (state_r != IDLE && state_r != DONE) begin
      // Unreachable encoding: recover to IDLE.
      state_r <= IDLE;
      done    <= 1'b0;
    end else begin
      state_r <= state_r;
    end
  end

endmodule
